inst_cache: RTL and testbench
=============================

# inst_cache

Direct-mapped instruction cache and fetch front-end between the IF stage (PC source) and `mem_ctrl`. It accepts one word-aligned fetch at a time and answers hits from on-chip storage. On a miss it drives the `if_addr`/`if_request` pair of `mem_ctrl`, waits for its `if_enable` pulse, fills the line and returns the instruction. A jump flush aborts any outstanding fetch, matching `mem_ctrl` dropping its IF transfer on `jump_or_not`.

## Interface
- `INDEX_BITS`, default 6: line index width; the cache holds 2^INDEX_BITS lines of one 32-bit word each.
- `ADDR_LEN`, default 32: address width; equals `AddrLen`.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `rdy` input 1: global enable; when low, all state holds.
- `fetch_req` input 1: IF requests the instruction at `fetch_addr`. Level signal.
- `fetch_addr` input ADDR_LEN: fetch PC. Bits [1:0] are always 0.
- `flush` input 1: jump/mispredict; connected to the same net as `mem_ctrl.jump_or_not`.
- `inst` output 32: returned instruction.
- `inst_valid` output 1: one-cycle pulse; `inst` is valid in that cycle.
- `mem_if_addr` output ADDR_LEN: drives `mem_ctrl.if_addr`.
- `mem_if_request` output 1: drives `mem_ctrl.if_request`.
- `mem_if_inst` input 32: from `mem_ctrl.if_inst`.
- `mem_if_enable` input 1: from `mem_ctrl.if_enable`; one-cycle completion pulse.

## Operation
- Address split:
  - tag = addr[ADDR_LEN-1 : INDEX_BITS+2]
  - index = addr[INDEX_BITS+1 : 2]
- Storage per line: valid bit, tag, 32-bit data. Reset clears all valid bits only.
- States: IDLE, MISS, DONE.
  - IDLE, `fetch_req`=1, `flush`=0:
    - Hit (valid and tag match): latch data, go to DONE.
    - Miss: latch `fetch_addr` into `mem_if_addr`, set `mem_if_request`=1, go to MISS.
  - MISS: hold `mem_if_request`=1 and `mem_if_addr` stable.
    - On `mem_if_enable`=1: write valid/tag/data at the latched index, latch `mem_if_inst`, clear `mem_if_request`, go to DONE.
  - DONE: `inst_valid`=1 for exactly this cycle with the latched word, then return to IDLE.
    - A new request is not evaluated in DONE; IF must drop or change `fetch_req`/`fetch_addr` after the pulse.
- Flush, any state: go to IDLE, clear `mem_if_request` and `inst_valid` on the next edge. No line write occurs. A pending DONE pulse is suppressed.
- Flush takes priority over `mem_if_enable` and over `fetch_req` in the same cycle. A fetch presented together with `flush` is ignored.
- IF holds `fetch_addr` stable while `fetch_req`=1 until `inst_valid`. The cache samples the address only in IDLE.
- `rdy`=0 freezes the FSM, registers and storage. Inputs are ignored, outputs hold.

## Timing
- Reset values: `inst`=0, `inst_valid`=0, `mem_if_addr`=0, `mem_if_request`=0, FSM=IDLE, all valid bits=0.
- Hit latency: request sampled at edge N, `inst_valid` high in cycle N+1. Throughput is one fetch per 2 cycles.
- Miss latency: `mem_if_request` high from cycle N+1. `mem_if_enable` arrives at edge M; `inst_valid` is high in cycle M+1. With `mem_ctrl` from FREE, M ≥ N+5.
- `mem_if_request` is registered and never toggles mid-transfer except on flush.
- A hit immediately after a fill of the same line, at cycle M+2, returns the filled word.

## Configuration
- `ICACHE_EN` defined: behaviour as above.
- `ICACHE_EN` undefined: the storage array is not instantiated and every fetch takes the MISS path. Latency, handshake and flush rules are unchanged; hits never occur.

## Test plan
- Reset, then fetch 0x00000000 → `mem_if_request`=1 with `mem_if_addr`=0x0. Return `mem_if_inst`=0x00000013 with enable → next cycle `inst_valid`=1, `inst`=0x00000013.
- Re-fetch 0x00000000 → `inst_valid` one cycle after the request, `inst`=0x00000013, `mem_if_request` stays 0.
- Fetch 0x00000100 (INDEX_BITS=6, same index 0) → miss; fill 0x00100093. Then fetch 0x00000000 → miss again, because the line was replaced.
- Fetch 0x00000004, then assert `flush` two cycles into MISS → `mem_if_request`=0 next cycle, no `inst_valid`. A later fetch of 0x4 misses again.
- Hold `rdy`=0 for 3 cycles during MISS → outputs frozen. A `mem_if_enable` pulse during that window is ignored; completion follows the first enable seen with `rdy`=1.
- Build without `ICACHE_EN`: fetch 0x0 twice → two separate memory requests, identical `inst`.

Source files
------------

// File: rtl/inst_cache_if.sv
// IF-side and mem_ctrl-side signals of the instruction cache.
// The cache uses the slave modport; the fetch stage and mem_ctrl use the master modport.
interface inst_cache_if #(
  parameter int ADDR_LEN = 32
);
  logic                fetch_req;
  logic [ADDR_LEN-1:0] fetch_addr;
  logic                flush;
  logic [31:0]         inst;
  logic                inst_valid;
  logic [ADDR_LEN-1:0] mem_if_addr;
  logic                mem_if_request;
  logic [31:0]         mem_if_inst;
  logic                mem_if_enable;

  modport slave (
    input  fetch_req, fetch_addr, flush, mem_if_inst, mem_if_enable,
    output inst, inst_valid, mem_if_addr, mem_if_request
  );

  modport master (
    output fetch_req, fetch_addr, flush, mem_if_inst, mem_if_enable,
    input  inst, inst_valid, mem_if_addr, mem_if_request
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache in front of mem_ctrl.
// Define ICACHE_EN to build the storage array; otherwise every fetch goes to memory.
module inst_cache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_LEN   = 32
) (
  input logic        clk,
  input logic        rst,
  input logic        rdy,
  inst_cache_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MISS, DONE} state_t;

  state_t              state_q, state_n;
  logic [ADDR_LEN-1:0] addr_q, addr_n;
  logic                req_q, req_n;
  logic [31:0]         inst_q, inst_n;
  logic                valid_q;
  logic                hit;
  logic [31:0]         line_data;

`ifdef ICACHE_EN
  localparam int TAG_W = ADDR_LEN - INDEX_BITS - 2;
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      line_valid;
  logic [TAG_W-1:0]      line_tag  [LINES];
  logic [31:0]           line_word [LINES];
  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic                  fill;

  assign rd_idx    = bus.fetch_addr[INDEX_BITS+1:2];
  assign rd_tag    = bus.fetch_addr[ADDR_LEN-1:INDEX_BITS+2];
  assign wr_idx    = addr_q[INDEX_BITS+1:2];
  assign hit       = line_valid[rd_idx] && (line_tag[rd_idx] == rd_tag);
  assign line_data = line_word[rd_idx];
  assign fill      = (state_q == MISS) && bus.mem_if_enable && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      line_valid <= '0;
    else if (rdy && fill)
      line_valid[wr_idx] <= 1'b1;
  end

  // Tag/data need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      line_tag[wr_idx]  <= addr_q[ADDR_LEN-1:INDEX_BITS+2];
      line_word[wr_idx] <= bus.mem_if_inst;
    end
  end
`else
  assign hit       = 1'b0;
  assign line_data = '0;
`endif

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    req_n   = req_q;
    inst_n  = inst_q;
    if (bus.flush) begin
      state_n = IDLE;
      req_n   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.fetch_req) begin
            if (hit) begin
              inst_n  = line_data;
              state_n = DONE;
            end else begin
              addr_n  = bus.fetch_addr;
              req_n   = 1'b1;
              state_n = MISS;
            end
          end
        end
        MISS: begin
          if (bus.mem_if_enable) begin
            inst_n  = bus.mem_if_inst;
            req_n   = 1'b0;
            state_n = DONE;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      req_q   <= 1'b0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else if (rdy) begin
      state_q <= state_n;
      addr_q  <= addr_n;
      req_q   <= req_n;
      inst_q  <= inst_n;
      valid_q <= (state_n == DONE);
    end
  end

  assign bus.inst           = inst_q;
  assign bus.inst_valid     = valid_q;
  assign bus.mem_if_addr    = addr_q;
  assign bus.mem_if_request = req_q;

endmodule

// File: tb/tb_inst_cache.sv
// Directed cycle-table bench for inst_cache; expectations follow ICACHE_EN.
module tb_inst_cache;

  logic clk;
  logic rst;
  logic rdy;

  inst_cache_if #(.ADDR_LEN(32)) bus ();

  inst_cache #(.INDEX_BITS(6), .ADDR_LEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] name;
    logic         rdy;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic         flush;
    logic [31:0]  mem_inst;
    logic         mem_en;
    logic         exp_valid;
    logic [31:0]  exp_inst;
    logic [31:0]  exp_addr;
    logic         exp_req;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic [127:0] nm, input logic r, input logic fr,
                     input logic [31:0] fa, input logic fl, input logic [31:0] mi,
                     input logic me, input logic ev, input logic [31:0] ei,
                     input logic [31:0] ea, input logic er);
    vec_t v;
    v.name = nm; v.rdy = r; v.fetch_req = fr; v.fetch_addr = fa; v.flush = fl;
    v.mem_inst = mi; v.mem_en = me; v.exp_valid = ev; v.exp_inst = ei;
    v.exp_addr = ea; v.exp_req = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input logic [127:0] nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fr, input logic [31:0] fa,
                       input logic fl, input logic [31:0] mi, input logic me);
    rdy = r; bus.fetch_req = fr; bus.fetch_addr = fa; bus.flush = fl;
    bus.mem_if_inst = mi; bus.mem_if_enable = me;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input logic [127:0] nm, input logic ev, input logic [31:0] ei,
                         input logic [31:0] ea, input logic er);
    chk(nm, {31'd0, bus.inst_valid}, {31'd0, ev});
    chk(nm, bus.inst, ei);
    chk(nm, bus.mem_if_addr, ea);
    chk(nm, {31'd0, bus.mem_if_request}, {31'd0, er});
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // Fill 0x0, then re-fetch it.
    add("a_req",   1, 1, 32'h0, 0, 32'h0,        0, 0, 32'h0,        32'h0, 1);
    add("a_wait",  1, 1, 32'h0, 0, 32'h0,        0, 0, 32'h0,        32'h0, 1);
    add("a_fill",  1, 1, 32'h0, 0, 32'h00000013, 1, 1, 32'h00000013, 32'h0, 0);
    add("a_idle",  1, 0, 32'h0, 0, 32'h0,        0, 0, 32'h00000013, 32'h0, 0);
`ifdef ICACHE_EN
    add("b_hit",   1, 1, 32'h0, 0, 32'h0,        0, 1, 32'h00000013, 32'h0, 0);
`else
    add("b_req",   1, 1, 32'h0, 0, 32'h0,        0, 0, 32'h00000013, 32'h0, 1);
    add("b_fill",  1, 1, 32'h0, 0, 32'h00000013, 1, 1, 32'h00000013, 32'h0, 0);
`endif
    add("b_idle",  1, 0, 32'h0, 0, 32'h0,        0, 0, 32'h00000013, 32'h0, 0);
    // Conflict at index 0 replaces the line; DONE ignores a held request.
    add("c_req",   1, 1, 32'h100, 0, 32'h0,        0, 0, 32'h00000013, 32'h100, 1);
    add("c_fill",  1, 1, 32'h100, 0, 32'h00100093, 1, 1, 32'h00100093, 32'h100, 0);
    add("c_idle",  1, 0, 32'h100, 0, 32'h0,        0, 0, 32'h00100093, 32'h100, 0);
    add("c_re0",   1, 1, 32'h0,   0, 32'h0,        0, 0, 32'h00100093, 32'h0,   1);
    add("c_fill0", 1, 1, 32'h0,   0, 32'h00000013, 1, 1, 32'h00000013, 32'h0,   0);
    add("c_doneig",1, 1, 32'h0,   0, 32'h0,        0, 0, 32'h00000013, 32'h0,   0);
`ifdef ICACHE_EN
    add("c_hit_m2",1, 1, 32'h0,   0, 32'h0,        0, 1, 32'h00000013, 32'h0,   0);
`else
    add("c_mis_m2",1, 1, 32'h0,   0, 32'h0,        0, 0, 32'h00000013, 32'h0,   1);
    add("c_fil_m2",1, 1, 32'h0,   0, 32'h00000013, 1, 1, 32'h00000013, 32'h0,   0);
`endif
    add("c_idle2", 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h00000013, 32'h0,   0);
    // Flush: fetch-with-flush ignored; flush beats enable mid-MISS, no line write.
    add("d_flfet", 1, 1, 32'h4, 1, 32'h0,        0, 0, 32'h00000013, 32'h0, 0);
    add("d_req",   1, 1, 32'h4, 0, 32'h0,        0, 0, 32'h00000013, 32'h4, 1);
    add("d_miss1", 1, 1, 32'h4, 0, 32'h0,        0, 0, 32'h00000013, 32'h4, 1);
    add("d_flush", 1, 1, 32'h4, 1, 32'hdeadbeef, 1, 0, 32'h00000013, 32'h4, 0);
    add("d_idle",  1, 0, 32'h4, 0, 32'h0,        0, 0, 32'h00000013, 32'h4, 0);
    add("d_req2",  1, 1, 32'h4, 0, 32'h0,        0, 0, 32'h00000013, 32'h4, 1);
    add("d_fill",  1, 1, 32'h4, 0, 32'h00400113, 1, 1, 32'h00400113, 32'h4, 0);
    add("d_idle2", 1, 0, 32'h4, 0, 32'h0,        0, 0, 32'h00400113, 32'h4, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].fetch_req, vecs[i].fetch_addr, vecs[i].flush,
            vecs[i].mem_inst, vecs[i].mem_en);
      tick();
      chk_all(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_inst, vecs[i].exp_addr,
              vecs[i].exp_req);
    end

    // rdy low for three cycles inside MISS: enable and flush there are ignored.
    drive(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
    tick();
    chk_all("e_req", 1'b0, 32'h00400113, 32'h8, 1'b1);
    drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
    tick();
    chk_all("e_frz1", 1'b0, 32'h00400113, 32'h8, 1'b1);
    drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h00000bad, 1'b1);
    tick();
    chk_all("e_frz2", 1'b0, 32'h00400113, 32'h8, 1'b1);
    drive(1'b0, 1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
    tick();
    chk_all("e_frz3", 1'b0, 32'h00400113, 32'h8, 1'b1);
    drive(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
    tick();
    chk_all("e_resume", 1'b0, 32'h00400113, 32'h8, 1'b1);
    drive(1'b1, 1'b1, 32'h8, 1'b0, 32'h00800193, 1'b1);
    seen = 1'b0;
    for (int unsigned c = 0; c < 4 && !seen; c++) begin
      tick();
      drive(1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 1'b0);
      if (bus.inst_valid) seen = 1'b1;
    end
    chk("e_seen", {31'd0, seen}, 32'd1);
    chk("e_inst", bus.inst, 32'h00800193);
    tick();
    chk_all("e_idle", 1'b0, 32'h00800193, 32'h8, 1'b0);
`ifdef ICACHE_EN
    drive(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
    tick();
    chk_all("e_hit", 1'b1, 32'h00800193, 32'h8, 1'b0);
    drive(1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 1'b0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
